mux_scan_capture: RTL and testbench

- Sequential controller that sits directly in front of the board's dual 4-to-1 selector stage (74153-style: 2-bit select a1/a0, active-low strobe g, single output y) and consumes that selector's output.
- On each scan it steps the select through inputs 0..3 with the strobe enabled, samples y at each step and packs the four samples into a 4-bit word for LEDs or a downstream register.
- Used to read all four selector data inputs automatically instead of setting the select lines by hand with switches.

---
 rtl/mux_scan_capture.sv | 77 +++++++
 tb/tb_mux_scan_capture.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps a 74153-style selector through inputs 0..3 and packs
// the synchronized samples of its output into a 4-bit word.
module mux_scan_capture #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_y,
  output logic       sel_a1,
  output logic       sel_a0,
  output logic       mux_g,
  output logic [3:0] word,
  output logic       word_valid,
  output logic       busy
);
  localparam int CW = $clog2(DWELL);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  if (DWELL < 3) begin : g_dwell_chk
    $error("DWELL must be at least 3 to cover synchronizer latency");
  end
  logic [0:0]    r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_shadow;
  logic          r_meta;
  logic          r_sync;
  logic [3:0]    r_word;
  logic          r_valid;
  logic          w_last;
  assign w_last     = r_cnt == LAST;
  assign busy       = r_state == S_SCAN;
  assign mux_g      = ~busy;
  // idx is held at 0 outside a scan, so it doubles as the select output
  assign {sel_a1, sel_a0} = r_idx;
  assign word       = r_word;
  assign word_valid = r_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      r_shadow <= 3'd0;
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_word   <= 4'd0;
      r_valid  <= 1'b0;
    end else begin
      r_meta  <= mux_y;
      r_sync  <= r_meta;
      r_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_state <= S_SCAN;
          r_idx   <= 2'd0;
          r_cnt   <= '0;
        end
      end else if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
        if (r_idx != 2'd3) begin
          r_shadow[r_idx] <= r_sync;
          r_idx           <= r_idx + 1'b1;
        end else begin
          r_word  <= {r_sync, r_shadow};
          r_valid <= 1'b1;
          r_idx   <= 2'd0;
          r_state <= cont ? S_SCAN : S_IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_capture.sv
// tb_mux_scan_capture: drives mux_scan_capture through a behavioural 4-to-1
// selector and checks words, select stepping and pulse timing.
module tb_mux_scan_capture;
  localparam int DW = 4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic       mux_y;
  logic       sel_a1;
  logic       sel_a0;
  logic       mux_g;
  logic [3:0] word;
  logic       word_valid;
  logic       busy;
  logic [3:0] d;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  mux_scan_capture #(.DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mux_y(mux_y),
    .sel_a1(sel_a1), .sel_a0(sel_a0), .mux_g(mux_g), .word(word),
    .word_valid(word_valid), .busy(busy)
  );
  assign mux_y = mux_g ? 1'b0 : d[{sel_a1, sel_a0}];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic wait_valid(output int t, output bit saw_idle);
    saw_idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) saw_idle = 1'b1;
      if (word_valid) begin
        t = cyc;
        return;
      end
    end
    t = cyc;
    check("valid_timeout", 0, 1);
  endtask
  // One scan from IDLE; expected select index is simply elapsed cycles / DWELL
  task automatic run_scan(input logic [3:0] dv, input logic [3:0] exp, input int start_k,
                          input int d_k, input logic [3:0] dnew);
    d = dv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4 * DW; k++) begin
      if (k == start_k) start = 1'b1;
      if (k == start_k + 1) start = 1'b0;
      if (k == d_k) d = dnew;
      check("scan_sel", {sel_a1, sel_a0}, k / DW);
      check("scan_g", mux_g, 0);
      check("scan_busy", busy, 1);
      check("scan_valid", word_valid, 0);
      @(negedge clk);
    end
    check("end_valid", word_valid, 1);
    check("end_word", word, exp);
    check("end_busy", busy, 0);
    check("end_g", mux_g, 1);
    @(negedge clk);
    check("pulse_width", word_valid, 0);
    check("word_hold", word, exp);
  endtask
  initial begin
    int t1, t2, t3, seen;
    bit idle;
    logic [3:0] r;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; d = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_word", word, 0);
    check("rst_sel", {sel_a1, sel_a0}, 0);
    check("rst_g", mux_g, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", word_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(4'b1010, 4'b1010, -1, -1, 4'h0);
    cont = 1'b1; d = 4'b0110; start = 1'b1;
    wait_valid(t1, idle);
    check("cont_word1", word, 4'b0110);
    check("cont_busy1", busy, 1);
    d = 4'b1001; start = 1'b0;
    wait_valid(t2, idle);
    check("cont_word2", word, 4'b1001);
    check("cont_period", t2 - t1, 4 * DW);
    check("cont_no_idle", idle, 0);
    cont = 1'b0;
    wait_valid(t3, idle);
    check("cont_word3", word, 4'b1001);
    check("cont_period2", t3 - t2, 4 * DW);
    @(negedge clk);
    check("cont_stop_busy", busy, 0);
    run_scan(4'b0011, 4'b0011, 5, -1, 4'h0);
    run_scan(4'hF, 4'hF, -1, -1, 4'h0);
    d = 4'b0101; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_word", word, 0);
    check("mid_rst_sel", {sel_a1, sel_a0}, 0);
    check("mid_rst_g", mux_g, 1);
    check("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (word_valid) seen++;
    end
    check("mid_rst_no_valid", seen, 0);
    run_scan(4'b1100, 4'b1100, -1, -1, 4'h0);
    d = 4'hF; start = 1'b1;
    wait_valid(t1, idle);
    check("held_word1", word, 4'hF);
    wait_valid(t2, idle);
    check("held_word2", word, 4'hF);
    check("held_period", t2 - t1, 4 * DW + 1);
    start = 1'b0;
    @(negedge clk);
    check("held_stop_busy", busy, 0);
    run_scan(4'b1001, 4'b1001, -1, 2 * DW, 4'b1011);
    run_scan(4'b1011, 4'b1011, -1, -1, 4'h0);
    for (int i = 0; i < 12; i++) begin
      r = 4'($urandom);
      run_scan(r, r, -1, -1, 4'h0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
